// File: rtl/time_adjuster.sv
// Hours/minutes/seconds time registers with key-driven field adjustment
// (edge detect plus auto-repeat) in set mode and 1 Hz advance with full carry in run mode.
//
// Repeat FSM
//   state  | meaning
//   IDLE   | key released, waiting for a falling edge
//   HOLD   | key held, counting toward the first auto-repeat step
//   REPEAT | key held past the hold time, stepping every REPEAT_CYCLES
module time_adjuster #(
   parameter int unsigned HOLD_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_mode,
   input  logic       tick_1hz,
   input  logic       IncPress,
   input  logic [1:0] Select,
   input  logic       s,
   input  logic       res,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       day_carry,
   output logic       sel_err
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   logic             key_sync1;
   logic             key_sync2;
   logic             key_prev;
   logic             press;
   logic             rpt_step;
   logic             step;
   logic             sel_ok;

   rpt_state_t       state;
   rpt_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic [4:0]       hours_inc;
   logic [5:0]       minutes_inc;
   logic [5:0]       seconds_inc;
   logic [4:0]       hours_nxt;
   logic [5:0]       minutes_nxt;
   logic [5:0]       seconds_nxt;
   logic             day_carry_nxt;
   logic             sel_err_nxt;

   // Key is active-low; the synchronizer presets to the released level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         key_sync1 <= 1'b1;
         key_sync2 <= 1'b1;
         key_prev  <= 1'b1;
      end else begin
         key_sync1 <= IncPress;
         key_sync2 <= key_sync1;
         key_prev  <= key_sync2;
      end
   end

   assign press = key_prev & ~key_sync2;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rpt_step  = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end
         end
         HOLD: begin
            if (key_sync2) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == HOLD_TC) begin
               rpt_step  = 1'b1;
               state_nxt = REPEAT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         REPEAT: begin
            if (key_sync2) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == REPEAT_TC) begin
               rpt_step = 1'b1;
               cnt_nxt  = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign step   = press | rpt_step;
   assign sel_ok = (Select != 2'b11) && (s == (Select == 2'b10));

   assign hours_inc   = (hours   >= 5'd23) ? 5'd0 : hours   + 5'd1;
   assign minutes_inc = (minutes >= 6'd59) ? 6'd0 : minutes + 6'd1;
   assign seconds_inc = (seconds >= 6'd59) ? 6'd0 : seconds + 6'd1;

   // set_mode picks exactly one path per edge, so a step and a tick never both act.
   always_comb begin
      hours_nxt     = hours;
      minutes_nxt   = minutes;
      seconds_nxt   = seconds;
      day_carry_nxt = 1'b0;
      sel_err_nxt   = sel_err;
      if (set_mode) begin
         if (step) begin
            if (!sel_ok) begin
               sel_err_nxt = 1'b1;
            end else begin
               case (Select)
                  2'b10:   hours_nxt   = hours_inc;
                  2'b01:   minutes_nxt = minutes_inc;
                  2'b00:   seconds_nxt = res ? 6'd0 : seconds_inc;
                  default: sel_err_nxt = 1'b1;
               endcase
            end
         end
      end else if (tick_1hz) begin
         seconds_nxt = seconds_inc;
         if (seconds >= 6'd59) begin
            minutes_nxt = minutes_inc;
            if (minutes >= 6'd59) begin
               hours_nxt = hours_inc;
               if (hours >= 5'd23) begin
                  day_carry_nxt = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hours     <= 5'd0;
         minutes   <= 6'd0;
         seconds   <= 6'd0;
         day_carry <= 1'b0;
         sel_err   <= 1'b0;
      end else begin
         hours     <= hours_nxt;
         minutes   <= minutes_nxt;
         seconds   <= seconds_nxt;
         day_carry <= day_carry_nxt;
         sel_err   <= sel_err_nxt;
      end
   end

endmodule

// File: tb/tb_time_adjuster.sv
// Self-checking bench for time_adjuster: directed scenarios plus randomized
// stimulus against a wall-clock style reference model.
module tb_time_adjuster;

   localparam int H = 8;
   localparam int R = 3;
   localparam longint FAR = 64'd1000000000;

   logic       clk = 1'b0;
   logic       reset;
   logic       set_mode;
   logic       tick_1hz;
   logic       IncPress;
   logic [1:0] Select;
   logic       s;
   logic       res;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       day_carry;
   logic       sel_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: edge index, key fall/release edges, time fields.
   longint edge_n = 0;
   longint fall_e = -1000;
   longint rel_e  = -1000;
   logic   key_prev = 1'b1;
   int     m_h = 0, m_m = 0, m_s = 0;
   logic   m_dc = 1'b0, m_err = 1'b0;

   time_adjuster #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
      .clk(clk), .reset(reset), .set_mode(set_mode), .tick_1hz(tick_1hz),
      .IncPress(IncPress), .Select(Select), .s(s), .res(res),
      .hours(hours), .minutes(minutes), .seconds(seconds),
      .day_carry(day_carry), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   // A fall seen before edge F yields a step at F+2, then at F+2+H+k*R while
   // the key is still held as seen two edges after its release.
   function automatic bit step_at(input longint n);
      if (n == fall_e + 2) return 1'b1;
      if (n >= fall_e + 2 + H && n <= rel_e + 1 && ((n - fall_e - 2 - H) % R) == 0) return 1'b1;
      return 1'b0;
   endfunction

   // Called at a negedge: drives inputs for the next posedge, predicts the
   // outputs after that edge, and returns at the following negedge.
   task automatic drive_cycle(input logic inc, input logic sm, input logic tk,
                              input logic [1:0] sel, input logic sv, input logic rs);
      int t;
      IncPress = inc; set_mode = sm; tick_1hz = tk; Select = sel; s = sv; res = rs;
      if (!reset) begin
         m_h = 0; m_m = 0; m_s = 0; m_dc = 1'b0; m_err = 1'b0;
         fall_e = -1000; rel_e = -1000; key_prev = 1'b1;
      end else begin
         if (!inc && key_prev) begin fall_e = edge_n; rel_e = FAR; end
         if (inc && !key_prev) rel_e = edge_n;
         key_prev = inc;
         m_dc = 1'b0;
         if (sm) begin
            if (step_at(edge_n)) begin
               if (sel == 2'b11 || sv != (sel == 2'b10)) m_err = 1'b1;
               else if (sel == 2'b10) m_h = (m_h + 1) % 24;
               else if (sel == 2'b01) m_m = (m_m + 1) % 60;
               else m_s = rs ? 0 : (m_s + 1) % 60;
            end
         end else if (tk) begin
            t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_dc = (t == 0);
            m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
         end
      end
      edge_n++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic press_n(input int n, input logic [1:0] sel, input logic sv, input logic rs);
      for (int i = 0; i < n; i++) begin
         drive_cycle(1'b0, 1'b1, 1'b0, sel, sv, rs);
         repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, sel, sv, rs);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      for (int i = 0; i < 3; i++)
         drive_cycle((i == 2) ? 1'b1 : 1'($urandom), 1'($urandom), 1'($urandom),
                     2'($urandom), 1'($urandom), 1'($urandom));
      n_checks++;
      if ({hours, minutes, seconds, day_carry, sel_err} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_values: got h=%0d m=%0d s=%0d dc=%b err=%b, want all 0",
                  hours, minutes, seconds, day_carry, sel_err);
      end
      reset = 1'b1;
      repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if ({hours, minutes, seconds, day_carry, sel_err} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got h=%0d m=%0d s=%0d dc=%b err=%b, want all 0",
                  hours, minutes, seconds, day_carry, sel_err);
      end
   endtask

   task automatic test_hours_wrap;
      press_n(23, 2'b10, 1'b1, 1'b0);
      n_checks++;
      if (hours !== 5'd23 || hours !== 5'(m_h)) begin
         n_fail++;
         $display("FAIL hours_to_23: got %0d, want 23 (model %0d)", hours, m_h);
      end
      drive_cycle(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
      n_checks++;
      if (hours !== 5'd23) begin
         n_fail++;
         $display("FAIL hours_latency_early: got %0d after 2 edges, want 23", hours);
      end
      drive_cycle(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd0, 6'd0, 6'd0}) begin
         n_fail++;
         $display("FAIL hours_wrap: got %0d:%0d:%0d after 3 edges, want 0:0:0", hours, minutes, seconds);
      end
      repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
   endtask

   task automatic test_seconds_minutes;
      press_n(37, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (seconds !== 6'd37) begin
         n_fail++;
         $display("FAIL seconds_to_37: got %0d, want 37", seconds);
      end
      press_n(1, 2'b00, 1'b0, 1'b1);
      n_checks++;
      if (seconds !== 6'd0 || minutes !== 6'd0) begin
         n_fail++;
         $display("FAIL seconds_clear: got s=%0d m=%0d, want s=0 m=0", seconds, minutes);
      end
      press_n(59, 2'b01, 1'b0, 1'b0);
      n_checks++;
      if (minutes !== 6'd59) begin
         n_fail++;
         $display("FAIL minutes_to_59: got %0d, want 59", minutes);
      end
      press_n(1, 2'b01, 1'b0, 1'b0);
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd0, 6'd0, 6'd0}) begin
         n_fail++;
         $display("FAIL minutes_wrap: got %0d:%0d:%0d, want 0:0:0", hours, minutes, seconds);
      end
   endtask

   task automatic test_autorepeat;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
         if (i == 9) begin
            n_checks++;
            if (minutes !== 6'd1) begin
               n_fail++;
               $display("FAIL repeat_before_hold: got %0d one edge before first repeat, want 1", minutes);
            end
         end
         if (i == 10) begin
            n_checks++;
            if (minutes !== 6'd2) begin
               n_fail++;
               $display("FAIL repeat_first_step: got %0d at hold end, want 2", minutes);
            end
         end
      end
      drive_cycle(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      n_checks++;
      if (minutes !== 6'd5 || minutes !== 6'(m_m)) begin
         n_fail++;
         $display("FAIL repeat_count: got %0d, want 5 (model %0d)", minutes, m_m);
      end
      repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      n_checks++;
      if (minutes !== 6'd5) begin
         n_fail++;
         $display("FAIL repeat_release: got %0d after release, want 5", minutes);
      end
   endtask

   task automatic test_run_carry;
      press_n(23, 2'b10, 1'b1, 1'b0);
      press_n(54, 2'b01, 1'b0, 1'b0);
      press_n(59, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59}) begin
         n_fail++;
         $display("FAIL preset_235959: got %0d:%0d:%0d, want 23:59:59", hours, minutes, seconds);
      end
      drive_cycle(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if ({hours, minutes, seconds, day_carry} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL day_rollover: got %0d:%0d:%0d dc=%b, want 0:0:0 dc=1", hours, minutes, seconds, day_carry);
      end
      drive_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (day_carry !== 1'b0 || seconds !== 6'd0) begin
         n_fail++;
         $display("FAIL day_carry_pulse: got dc=%b s=%0d, want dc=0 s=0", day_carry, seconds);
      end
      drive_cycle(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (seconds !== 6'd1 || day_carry !== 1'b0) begin
         n_fail++;
         $display("FAIL run_tick: got s=%0d dc=%b, want s=1 dc=0", seconds, day_carry);
      end
   endtask

   task automatic test_illegal_select;
      press_n(1, 2'b11, 1'b0, 1'b0);
      n_checks++;
      if ({hours, minutes, seconds, sel_err} !== {5'd0, 6'd0, 6'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL illegal_select: got %0d:%0d:%0d err=%b, want 0:0:1 err=1", hours, minutes, seconds, sel_err);
      end
      press_n(1, 2'b10, 1'b0, 1'b0);
      press_n(1, 2'b01, 1'b0, 1'b0);
      n_checks++;
      if ({hours, minutes, sel_err} !== {5'd0, 6'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL sel_err_sticky: got h=%0d m=%0d err=%b, want h=0 m=1 err=1", hours, minutes, sel_err);
      end
      reset = 1'b0;
      drive_cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      reset = 1'b1;
      drive_cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (sel_err !== 1'b0 || minutes !== 6'd0) begin
         n_fail++;
         $display("FAIL sel_err_reset: got err=%b m=%0d, want err=0 m=0", sel_err, minutes);
      end
   endtask

   task automatic test_random;
      logic       key = 1'b1;
      int         left = 4;
      logic       sm = 1'b1;
      logic [1:0] sel;
      logic       sv;
      int         r;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            reset = 1'b0;
            drive_cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
            reset = 1'b1;
            key = 1'b1; left = 4;
         end
         if (left == 0) begin
            key = ~key;
            if (key) left = $urandom_range(3, 8);
            else left = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 12);
         end
         left--;
         if ($urandom_range(0, 24) == 0) sm = ~sm;
         r = $urandom_range(0, 59);
         sel = (r < 20) ? 2'b00 : (r < 40) ? 2'b01 : (r < 59) ? 2'b10 : 2'b11;
         sv = (sel == 2'b10);
         if ($urandom_range(0, 79) == 0) sv = ~sv;
         drive_cycle(key, sm, ($urandom_range(0, 3) == 0), sel, sv, ($urandom_range(0, 7) == 0));
         n_checks++;
         if ({hours, minutes, seconds, day_carry, sel_err} !==
             {5'(m_h), 6'(m_m), 6'(m_s), m_dc, m_err}) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %0d:%0d:%0d dc=%b err=%b, want %0d:%0d:%0d dc=%b err=%b",
                     c, hours, minutes, seconds, day_carry, sel_err, m_h, m_m, m_s, m_dc, m_err);
         end
      end
   endtask

   initial begin
      reset = 1'b0; IncPress = 1'b1; set_mode = 1'b0; tick_1hz = 1'b0;
      Select = 2'b00; s = 1'b0; res = 1'b0;
      @(negedge clk);
      test_reset();
      test_hours_wrap();
      test_seconds_minutes();
      test_autorepeat();
      test_run_carry();
      test_illegal_select();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/time_adjuster.md
# time_adjuster

Holds the hours/minutes/seconds time registers of the clock and applies user adjustments to the field chosen by the state setter FSM. It is the consumer end of the `Select`/`s`/`res` interface: the setter picks the field, this block synchronizes the increment key, edge-detects it, auto-repeats while the key is held, and updates or clears the chosen field. Outside set mode it advances time from a 1 Hz tick with full carry.

## Interface
- `HOLD_CYCLES`, default 50_000_000: clk cycles the key must stay pressed before auto-repeat starts (1 s at 50 MHz).
- `REPEAT_CYCLES`, default 12_500_000: clk cycles between auto-repeat increments (4 Hz at 50 MHz).
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `set_mode` input 1: 1 = adjust mode, time frozen; 0 = run mode.
- `tick_1hz` input 1: one-`clk`-wide strobe, once per second.
- `IncPress` input 1: raw increment key, active-low (pressed = 0), asynchronous.
- `Select` input 2: field select from the setter. 2'b10 = hours, 2'b01 = minutes, 2'b00 = seconds, 2'b11 = illegal.
- `s` input 1: hours-state flag from the setter. It must be 1 exactly when `Select`=2'b10.
- `res` input 1: seconds-state flag. 1 = a press clears seconds instead of incrementing them.
- `hours` output 5: 0–23, binary.
- `minutes` output 6: 0–59, binary.
- `seconds` output 6: 0–59, binary.
- `day_carry` output 1: one-cycle pulse when the time rolls from 23:59:59 to 00:00:00 in run mode.
- `sel_err` output 1: sticky. Set when a press is seen with `Select`=2'b11, or with `s` not equal to (`Select`==2'b10). Cleared only by reset.

## Operation
- Reset (`reset`=0 at an edge): `hours`, `minutes` and `seconds` go to 0. `day_carry`=0, `sel_err`=0. Sync registers preset to 1 (key released). Repeat FSM goes to IDLE and its counter to 0.
- Key path:
  - Two-flop synchronizer, then a previous-value register.
  - `press` = previous & ~synced, i.e. a falling edge of the key.
- Repeat FSM:
  - IDLE: on `press`, go to HOLD with counter = 0.
  - HOLD: counter increments while the synced key = 0. When it reaches HOLD_CYCLES−1, emit a `step` and go to REPEAT with counter = 0.
  - REPEAT: emit a `step` every REPEAT_CYCLES cycles while the key is held.
  - From HOLD or REPEAT, synced key = 1 returns to IDLE.
  - `press` itself is also a `step`.
- Adjust mode (`set_mode`=1):
  - `tick_1hz` is ignored.
  - On each `step`, first check the field select. If `Select`=2'b11 or `s` mismatches, there is no field change and `sel_err` is set.
  - `Select`=2'b10: `hours` becomes (`hours`+1) mod 24.
  - `Select`=2'b01: `minutes` becomes (`minutes`+1) mod 60.
  - `Select`=2'b00 with `res`=1: `seconds` becomes 0.
  - `Select`=2'b00 with `res`=0: `seconds` becomes (`seconds`+1) mod 60.
  - No carry between fields in adjust mode: 59 wraps to 0 with the other fields unchanged.
- Run mode (`set_mode`=0):
  - Steps are discarded, but the key FSM still tracks the key.
  - On `tick_1hz`, increment `seconds`. 59 carries into `minutes`, 59 minutes carries into `hours`, and 23 wraps to 0 with `day_carry`=1 for that cycle.
- `set_mode` changing in the same cycle as a step or tick: the value of `set_mode` sampled at that edge decides which path acts. Step and tick never both apply in one cycle.
- `Select` changing while the key is held: each repeat step uses the `Select`/`s`/`res` sampled at that step's edge.

## Timing
- Key fall to field update:
  - `IncPress` low before edge N: synced at N+1, `press` high during N+1..N+2, field updated at edge N+2.
  - That is 3 rising edges counting N, and ≥2 full cycles after the fall.
- First auto-repeat step: HOLD_CYCLES cycles after the `press` step. Subsequent steps: every REPEAT_CYCLES cycles.
- Tick to update: `tick_1hz` high at edge N means fields are updated at edge N. `day_carry` is registered and is high for the cycle after edge N.
- Key release: returns to IDLE 2 edges after `IncPress` rises. No step is generated on release.
- Key glitches shorter than 1 cycle may be missed. Debounce is upstream.

## Test plan
- Reset and hold: hold `reset`=0 for 3 cycles with all inputs toggling → all outputs 0. `sel_err`=0.
- Adjust hours wrap: `set_mode`=1, `Select`=10, `s`=1, `hours`=23, one press → `hours`=0, with `minutes` and `seconds` unchanged, 3 edges after the fall.
- Seconds clear and minutes wrap:
  - `Select`=00, `res`=1, `seconds`=37, press → `seconds`=0.
  - `Select`=01, `minutes`=59, press → `minutes`=0, `hours` unchanged.
- Auto-repeat (HOLD_CYCLES=8, REPEAT_CYCLES=3): `Select`=01, `minutes`=0, key held 20 cycles after `press` → `minutes`=5 (press + step at 8 + steps at 11, 14, 17). Release → no further change.
- Run carry and illegal select:
  - `set_mode`=0 at 23:59:59, one tick → 00:00:00 and one-cycle `day_carry`.
  - Then `set_mode`=1, `Select`=11, press → fields unchanged and `sel_err`=1, sticky until reset.
